// File: rtl/btn_event_capture.sv
// CPU-side event capture for debounced push buttons: sticky press/release flags,
// saturating press counters, last-pressed index and a level interrupt.
module btn_event_capture #(
    parameter int N_BTN = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [1:0]       addr_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             irq_o
);
    // Register bus: we_i/re_i are single-cycle strobes with no back-pressure;
    // rdata_o carries the pre-update value the cycle after re_i and holds until the next re_i.

    // Register packing has four lanes; buttons beyond lane 3 are not visible on the bus.
    localparam int N_VIS = (N_BTN < 4) ? N_BTN : 4;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_IRQ_EN = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_LAST   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_BTN-1:0] btn_prev;
    logic [N_BTN-1:0] press_evt;
    logic [N_BTN-1:0] rel_evt;
    logic [N_BTN-1:0] press_flag;
    logic [N_BTN-1:0] rel_flag;
    logic [N_BTN-1:0] press_en;
    logic [N_BTN-1:0] rel_en;
    logic [N_BTN-1:0] press_clr;
    logic [N_BTN-1:0] rel_clr;
    logic [CNT_W-1:0] cnt [N_BTN];
    logic [1:0]       last_idx;
    logic             last_valid;
    logic [1:0]       first_idx;
    logic             any_press;
    logic             wr_status;
    logic             wr_en;
    logic             wr_count;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign press_evt = btn_i & ~btn_prev;
    assign rel_evt   = ~btn_i & btn_prev;

    assign wr_status = we_i && (addr_i == A_STATUS);
    assign wr_en     = we_i && (addr_i == A_IRQ_EN);
    assign wr_count  = we_i && (addr_i == A_COUNT);

    assign unused_wdata = ^wdata_i;

    always_comb begin
        press_clr = '0;
        rel_clr   = '0;
        for (int i = 0; i < N_VIS; i++) begin
            press_clr[i] = wr_status & wdata_i[4+i];
            rel_clr[i]   = wr_status & wdata_i[8+i];
        end
    end

    // Lowest pressed index wins when several buttons rise together.
    always_comb begin
        first_idx = '0;
        any_press = 1'b0;
        for (int i = N_VIS - 1; i >= 0; i--) begin
            if (press_evt[i]) begin
                first_idx = 2'(i);
                any_press = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            A_STATUS: begin
                for (int i = 0; i < N_VIS; i++) begin
                    rd_mux[i]   = btn_i[i];
                    rd_mux[4+i] = press_flag[i];
                    rd_mux[8+i] = rel_flag[i];
                end
            end
            A_IRQ_EN: begin
                for (int i = 0; i < N_VIS; i++) begin
                    rd_mux[i]   = press_en[i];
                    rd_mux[4+i] = rel_en[i];
                end
            end
            A_COUNT: begin
                for (int i = 0; i < N_VIS; i++) begin
                    rd_mux[8*i +: 8] = 8'(cnt[i]);
                end
            end
            default: begin
                rd_mux[1:0] = last_idx;
                rd_mux[2]   = last_valid;
            end
        endcase
    end

    // A press landing on a clearing write still counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (press_evt[i]) begin
                    if (wr_count) begin
                        cnt[i] <= CNT_ONE;
                    end else if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else if (wr_count) begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev   <= '0;
            press_flag <= '0;
            rel_flag   <= '0;
            press_en   <= '0;
            rel_en     <= '0;
            last_idx   <= '0;
            last_valid <= 1'b0;
            irq_o      <= 1'b0;
            rdata_o    <= '0;
        end else begin
            btn_prev   <= btn_i;
            press_flag <= (press_flag & ~press_clr) | press_evt;
            rel_flag   <= (rel_flag & ~rel_clr) | rel_evt;
            if (wr_en) begin
                for (int i = 0; i < N_VIS; i++) begin
                    press_en[i] <= wdata_i[i];
                    rel_en[i]   <= wdata_i[4+i];
                end
            end
            if (any_press) begin
                last_idx   <= first_idx;
                last_valid <= 1'b1;
            end
            irq_o <= (|(press_flag & press_en)) | (|(rel_flag & rel_en));
            if (re_i) begin
                rdata_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_capture.sv
// Bench for btn_event_capture: vector table for the register map, hand sequences
// for interrupt timing, set/clear races, saturation and mid-hold reset.
module tb_btn_event_capture;

    logic        clk;
    logic        rst;
    logic [3:0]  btn;
    logic [1:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [3:0]  btn;
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          reps;
        logic        chk_irq;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[18];

    btn_event_capture #(.N_BTN(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn),
        .addr_i  (addr),
        .we_i    (we),
        .re_i    (re),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive inputs, let one edge pass, then score any read issued.
    task automatic cyc(input logic [3:0] b, input logic w, input logic r, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input string nm);
        logic [31:0] e;
        string       n;
        btn   = b;
        we    = w;
        re    = r;
        addr  = a;
        wdata = wd;
        if (r) begin
            exp_q.push_back(er);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
        if (r) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, rdata, e);
        end
    endtask

    task automatic idle(input logic [3:0] b);
        cyc(b, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "");
    endtask

    task automatic rd(input logic [3:0] b, input logic [1:0] a, input logic [31:0] er, input string nm);
        cyc(b, 1'b0, 1'b1, a, 32'h0, er, nm);
    endtask

    task automatic wr(input logic [3:0] b, input logic [1:0] a, input logic [31:0] wd);
        cyc(b, 1'b1, 1'b0, a, wd, 32'h0, "");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        btn   = 4'b0000;
        addr  = 2'd0;
        we    = 1'b0;
        re    = 1'b0;
        wdata = 32'h0;

        //           btn     we    re    addr  wdata          exp            reps chk   irq   name
        vecs[0]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0000_0000, 1, 1'b1, 1'b0, "rst_status"};
        vecs[1]  = '{4'b0000, 1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "rst_irq_en"};
        vecs[2]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "rst_count"};
        vecs[3]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "rst_last"};
        vecs[4]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "b2_edge"};
        vecs[5]  = '{4'b0100, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0000_0044, 9, 1'b0, 1'b0, "b2_held_status"};
        vecs[6]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "b2_release"};
        vecs[7]  = '{4'b0000, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0000_0440, 1, 1'b1, 1'b0, "b2_rel_status"};
        vecs[8]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 32'h0,        32'h0001_0000, 1, 1'b0, 1'b0, "b2_count"};
        vecs[9]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 32'h0,        32'h0000_0006, 1, 1'b0, 1'b0, "b2_last"};
        vecs[10] = '{4'b0000, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0006, 1, 1'b0, 1'b0, "last_wr_rd"};
        vecs[11] = '{4'b0000, 1'b0, 1'b1, 2'd3, 32'h0,        32'h0000_0006, 1, 1'b0, 1'b0, "last_ro"};
        vecs[12] = '{4'b0000, 1'b1, 1'b1, 2'd0, 32'h0000_0FFF, 32'h0000_0440, 1, 1'b0, 1'b0, "w1c_rd_old"};
        vecs[13] = '{4'b0000, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0000_0000, 1, 1'b0, 1'b0, "w1c_cleared"};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 1'b0, "en_wr_all"};
        vecs[15] = '{4'b0000, 1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_00FF, 1, 1'b1, 1'b0, "irq_en_all"};
        vecs[16] = '{4'b0000, 1'b1, 1'b0, 2'd1, 32'h0000_0001, 32'h0000_0000, 1, 1'b0, 1'b0, "en_wr_one"};
        vecs[17] = '{4'b0000, 1'b0, 1'b1, 2'd1, 32'h0,        32'h0000_0001, 1, 1'b1, 1'b0, "irq_en_one"};

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                cyc(vecs[i].btn, vecs[i].we && (r == 0), vecs[i].re && (r == 0), vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp, vecs[i].name);
            end
            if (vecs[i].chk_irq) begin
                check({vecs[i].name, "_irq"}, {31'h0, irq}, {31'h0, vecs[i].exp_irq});
            end
        end

        // Interrupt path with only the b0 press enable set.
        idle(4'b0001);
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        idle(4'b0001);
        check("irq_2cyc", {31'h0, irq}, 32'h1);
        idle(4'b0000);
        check("irq_after_rel", {31'h0, irq}, 32'h1);
        wr(4'b0000, 2'd0, 32'h0000_0010);
        check("irq_hold_clr", {31'h0, irq}, 32'h1);
        idle(4'b0000);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd(4'b0000, 2'd0, 32'h0000_0100, "rel0_sticky");
        wr(4'b0000, 2'd0, 32'h0000_0100);

        // Clearing PRESS[1] on the very cycle b1 rises.
        wr(4'b0000, 2'd1, 32'h0000_0002);
        wr(4'b0010, 2'd0, 32'h0000_0020);
        idle(4'b0010);
        check("race_irq", {31'h0, irq}, 32'h1);
        rd(4'b0010, 2'd0, 32'h0000_0022, "race_status");
        check("race_irq_hold", {31'h0, irq}, 32'h1);
        idle(4'b0000);
        wr(4'b0000, 2'd0, 32'h0000_0FF0);
        wr(4'b0000, 2'd1, 32'h0000_0000);
        rd(4'b0000, 2'd3, 32'h0000_0005, "last_b1");

        // Saturation of the b3 counter with randomised hold and gap lengths.
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(1, 2)) idle(4'b1000);
            repeat ($urandom_range(1, 2)) idle(4'b0000);
            if (k == 253) rd(4'b0000, 2'd2, 32'hFE01_0101, "count_254");
        end
        rd(4'b0000, 2'd2, 32'hFF01_0101, "count_sat");
        rd(4'b0000, 2'd3, 32'h0000_0007, "last_b3");
        wr(4'b0000, 2'd0, 32'h0000_0FF0);

        // COUNT clear coinciding with a b0 press.
        wr(4'b0001, 2'd2, 32'h0);
        rd(4'b0001, 2'd2, 32'h0000_0001, "count_clr_race");
        idle(4'b0000);
        wr(4'b0000, 2'd0, 32'h0000_0FF0);
        wr(4'b0000, 2'd2, 32'h0);
        wr(4'b0000, 2'd1, 32'h0000_00FF);

        // Two buttons rising together, then reset while they are held.
        idle(4'b1010);
        rd(4'b1010, 2'd3, 32'h0000_0005, "simul_last");
        check("simul_irq", {31'h0, irq}, 32'h1);
        rd(4'b1010, 2'd0, 32'h0000_00AA, "simul_status");
        rd(4'b1010, 2'd2, 32'h0100_0100, "simul_count");

        rst  = 1'b1;
        re   = 1'b1;
        addr = 2'd0;
        @(posedge clk);
        #1;
        re  = 1'b0;
        check("rst_rdata_discard", rdata, 32'h0);
        check("rst_irq_mid", {31'h0, irq}, 32'h0);
        rst = 1'b0;

        idle(4'b1010);
        rd(4'b1010, 2'd0, 32'h0000_00AA, "post_rst_status");
        rd(4'b1010, 2'd2, 32'h0100_0100, "post_rst_count");
        rd(4'b1010, 2'd3, 32'h0000_0005, "post_rst_last");
        rd(4'b1010, 2'd1, 32'h0000_0000, "post_rst_en");
        check("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
